// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: state encodings,
// timeout default, alignment mask and the latched request record.
package mem_stage_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam int          TIMEOUT_DEF = 15;
  localparam logic [15:0] ALIGN_MASK  = 16'h0001;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    WAIT   = ST_WAIT,
    DONE   = ST_DONE,
    HALTED = ST_HALTED,
    ERROR  = ST_ERROR
  } state_e;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  function automatic logic misaligned(input logic [15:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_timer.sv
// Clearable up-counter; term flags the cycle in which an enabled count
// reaches LIMIT.
module wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  // Compared one below LIMIT so the flag fires in the LIMIT-th enabled cycle.
  assign term = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: one handshaked load/store per instruction,
// stalls the pipeline until completion, flags misalignment/timeouts.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        halt,
  output logic        mem_stall,
  output logic        done,
  output logic [15:0] mem_rdata,
  output logic        err,
  output logic        m_rd,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_busy,
  input  logic        m_rvalid,
  input  logic [15:0] m_rdata
);

  state_e   state, state_nxt;
  mem_req_t req_q;
  logic     latch_en, cap_en, tmr_clr, tmr_en, tmr_term;

  wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk  (clk),
    .rst_n(rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .term (tmr_term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_q     <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) req_q     <= '{write: req_write, addr: req_addr, wdata: req_wdata};
      if (cap_en)   mem_rdata <= m_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    latch_en  = 1'b0;
    cap_en    = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        // A request outranks halt; the HALT occupancy itself carries no access.
        if (req_valid) begin
          if (misaligned(req_addr)) begin
            state_nxt = ERROR;
          end else begin
            mem_stall = 1'b1;
            latch_en  = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (halt) begin
          state_nxt = HALTED;
        end
      end
      ISSUE: begin
        mem_stall = 1'b1;
        m_rd      = ~req_q.write;
        m_wr      = req_q.write;
        if (!m_busy) begin
          tmr_clr   = 1'b1;
          state_nxt = req_q.write ? DONE : WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        tmr_en    = 1'b1;
        // Returned data wins over a timeout in the same cycle.
        if (m_rvalid) begin
          cap_en    = 1'b1;
          state_nxt = DONE;
        end else if (tmr_term) begin
          state_nxt = ERROR;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      HALTED: state_nxt = HALTED;
      ERROR:  err = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_addr  = req_q.addr;
  assign m_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: table of single accesses plus
// hand-written sequences for misalignment, timeout, halt and reset.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, halt;
  logic [15:0] req_addr, req_wdata;
  logic        mem_stall, done, err, m_rd, m_wr;
  logic [15:0] mem_rdata, m_addr, m_wdata;
  logic        m_busy, m_rvalid;
  logic [15:0] m_rdata;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .halt(halt),
    .mem_stall(mem_stall), .done(done), .mem_rdata(mem_rdata), .err(err),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        wr;
    logic        halt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          busy;
    int          lat;       // 0 = never return data
    int          exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    halt = 1'b0; m_busy = 1'b0; m_rvalid = 1'b0; m_rdata = 16'hDEAD;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called and returns at posedge+1; cycle 0 is the IDLE cycle carrying the request.
  task automatic do_access(input vec_t v, input string tag);
    int done_cyc = -1;
    int strobes = 0;
    bit bad_strobe = 0, stall_bad = 0, err_seen = 0;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      req_valid = (c == 0);
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      halt      = v.halt && (c == 0);
      m_busy    = (c >= 1) && (c <= v.busy);
      m_rvalid  = (v.lat > 0) && (c == 1 + v.busy + v.lat);
      m_rdata   = m_rvalid ? v.rdata : 16'hDEAD;
      @(negedge clk);
      if (done) done_cyc = c;
      if (mem_stall !== (c < v.exp_done)) stall_bad = 1;
      if (m_rd || m_wr) begin
        strobes++;
        if (m_wr !== v.wr || m_rd !== !v.wr || m_addr !== v.addr ||
            (v.wr && m_wdata !== v.wdata)) bad_strobe = 1;
      end
      if (err) err_seen = 1;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk({tag, " done_cycle"}, done_cyc, v.exp_done);
    chk({tag, " strobe_cycles"}, strobes, v.busy + 1);
    chk({tag, " strobe_fields"}, bad_strobe, 0);
    chk({tag, " stall_window"}, stall_bad, 0);
    chk({tag, " no_err"}, err_seen, 0);
    chk({tag, " rdata_held"}, mem_rdata, v.exp_rdata);
    chk({tag, " single_done"}, done, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    int err_cyc, rds, act;
    bit done_seen, stall16, stall17;

    //        wr    halt  addr      wdata     rdata     busy lat done exp_rdata
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 0, 0,  2,  16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 2, 3,  7,  16'h1234};
    vecs[2] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, 0, 1,  3,  16'hA5A5};
    vecs[3] = '{1'b1, 1'b0, 16'h0102, 16'h5555, 16'h0000, 1, 0,  3,  16'hA5A5};
    vecs[4] = '{1'b0, 1'b0, 16'h0FFE, 16'h0000, 16'h0F0F, 0, 15, 17, 16'h0F0F};
    vecs[5] = '{1'b0, 1'b1, 16'h0008, 16'h0000, 16'h8001, 0, 2,  4,  16'h8001};

    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("reset outputs", {mem_stall, done, err, m_rd, m_wr}, 5'b0);
    chk("reset mem_rdata", mem_rdata, 16'h0000);
    chk("reset m_addr", m_addr, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) do_access(vecs[i], $sformatf("vec%0d", i));

    // Misaligned load: error next cycle, no access, later requests ignored.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0021;
    @(negedge clk);
    chk("misalign stall", mem_stall, 0);
    chk("misalign m_rd", m_rd, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("misalign err", err, 1);
    @(posedge clk); #1;
    act = 0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h1111;
      @(negedge clk);
      if (m_rd || m_wr || mem_stall || done || !err) act++;
      @(posedge clk); #1;
    end
    chk("error ignores requests", act, 0);

    // Timeout: load never returns data.
    do_reset();
    err_cyc = -1; rds = 0; done_seen = 0; stall16 = 0; stall17 = 1;
    for (int c = 0; c < 25; c++) begin
      req_valid = (c == 0); req_write = 1'b0; req_addr = 16'h0030;
      @(negedge clk);
      if (err && err_cyc < 0) err_cyc = c;
      if (done) done_seen = 1;
      if (m_rd) rds++;
      if (c == 16) stall16 = mem_stall;
      if (c == 17) stall17 = mem_stall;
      @(posedge clk); #1;
    end
    chk("timeout err cycle", err_cyc, 17);
    chk("timeout no done", done_seen, 0);
    chk("timeout rd cycles", rds, 1);
    chk("timeout stall last wait", stall16, 1);
    chk("timeout stall in error", stall17, 0);

    // Halt alone parks the stage.
    do_reset();
    halt = 1'b1;
    @(negedge clk);
    chk("halt stall", mem_stall, 0);
    @(posedge clk); #1;
    act = 0;
    for (int c = 0; c < 3; c++) begin
      halt = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h2222;
      @(negedge clk);
      if (m_rd || m_wr || mem_stall || done || err) act++;
      @(posedge clk); #1;
    end
    chk("halted ignores requests", act, 0);

    // Reset in the middle of a load.
    do_reset();
    v = '{1'b0, 1'b0, 16'h0050, 16'h0000, 16'h7E7E, 0, 2, 4, 16'h7E7E};
    do_access(v, "preload");
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0); req_write = 1'b0; req_addr = 16'h0060;
      @(negedge clk);
      if (c == 3) chk("mid-load stall", mem_stall, 1);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("async reset strobes", {m_rd, m_wr, done, err, mem_stall}, 5'b0);
    chk("async reset mem_rdata", mem_rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 1'b0, 16'h0070, 16'h0000, 16'hC3C3, 1, 1, 4, 16'hC3C3};
    do_access(v, "post-reset load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
